// File: rtl/rf2_ctrl_pkg.sv
// Shared types and constants for the rf2_32x128 register-file controller.
package rf2_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 128;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } wr_req_t;

    // Bitwise merge of a masked write onto older entry contents (mask bit 1 = take new bit).
    function automatic logic [DATA_W-1:0] merge_masked(input logic [DATA_W-1:0] old_v,
                                                       input logic [DATA_W-1:0] new_v,
                                                       input logic [DATA_W-1:0] mask_v);
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

endpackage

// File: rtl/rf2_32x128_ctrl_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer;
// the pointer moves to grant+1 only when the caller reports a completed transfer.
module rf_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W:0]   cand_s;
    logic             found_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant_o = {N{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand_s  = {(IDX_W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            cand_s = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N)) begin
                cand_s = cand_s - (IDX_W+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && valid_i[cand_s[IDX_W-1:0]]) begin
                found_s                    = 1'b1;
                grant_o[cand_s[IDX_W-1:0]] = 1'b1;
                idx_o                      = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advances past the winner only on an actual transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {IDX_W{1'b0}};
        end else if (advance_i) begin
            ptr_q <= (idx_o == IDX_W'(N-1)) ? {IDX_W{1'b0}} : idx_o + IDX_W'(1);
        end
    end

endmodule

// File: rtl/rf2_32x128_ctrl.sv
// Controller in front of one rf2_32x128_wm1 macro: zero-fills the array after reset,
// then round-robin shares the read port (A) and the masked write port (B).
// Optional build macro RF_BYPASS_EN: a read colliding with the granted write is granted
// and served at latency 3 (re-read plus merge); otherwise the colliding read is held off.
module rf2_32x128_ctrl
    import rf2_ctrl_pkg::*;
#(
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    localparam int RD_IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     init_done,
    input  logic [NUM_RD-1:0]        rd_req_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr,
    output logic [NUM_RD-1:0]        rd_req_ready,
    output logic                     rd_rsp_valid,
    output logic [RD_IDX_W-1:0]      rd_rsp_idx,
    output logic [DATA_W-1:0]        rd_rsp_data,
    input  logic [NUM_WR-1:0]        wr_req_valid,
    input  logic [NUM_WR*ADDR_W-1:0] wr_req_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_req_data,
    input  logic [NUM_WR*DATA_W-1:0] wr_req_mask,
    output logic [NUM_WR-1:0]        wr_req_ready,
    output logic                     ram_cena,
    output logic [ADDR_W-1:0]        ram_aa,
    input  logic [DATA_W-1:0]        ram_qa,
    output logic                     ram_cenb,
    output logic [DATA_W-1:0]        ram_wenb,
    output logic [ADDR_W-1:0]        ram_ab,
    output logic [DATA_W-1:0]        ram_db
);

    localparam int WR_IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    ctrl_state_e         state_q;
    logic [ADDR_W-1:0]   init_addr_q;
    logic                init_done_q;

    logic [NUM_RD-1:0]   rd_gnt_s;
    logic [RD_IDX_W-1:0] rd_idx_s;
    logic [NUM_WR-1:0]   wr_gnt_s;
    logic [WR_IDX_W-1:0] wr_idx_s;
    rd_req_t             rd_sel_s;
    wr_req_t             wr_sel_s;

    logic run_s, fill_s, rd_any_s, wr_any_s, addr_eq_s;
    logic rd_allow_s, wr_allow_s, collide_s, rd_fire_s, wr_fire_s, rd_issue_s;

    logic                p1_valid_q;
    logic [RD_IDX_W-1:0] p1_idx_q;
    logic [RD_IDX_W-1:0] p1_idx_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_valid_q;
    logic [RD_IDX_W-1:0] rsp_idx_q;
    logic [DATA_W-1:0]   rsp_data_q;

    rf_rr_arbiter #(.N(NUM_RD), .IDX_W(RD_IDX_W)) u_rd_arb (
        .clk(clk), .rst(reset), .valid_i(rd_req_valid), .advance_i(rd_fire_s),
        .grant_o(rd_gnt_s), .idx_o(rd_idx_s)
    );

    rf_rr_arbiter #(.N(NUM_WR), .IDX_W(WR_IDX_W)) u_wr_arb (
        .clk(clk), .rst(reset), .valid_i(wr_req_valid), .advance_i(wr_fire_s),
        .grant_o(wr_gnt_s), .idx_o(wr_idx_s)
    );

    // Pick out the request fields of the current arbitration winners.
    always_comb begin
        rd_sel_s.addr = rd_req_addr[int'(rd_idx_s)*ADDR_W +: ADDR_W];
        wr_sel_s.addr = wr_req_addr[int'(wr_idx_s)*ADDR_W +: ADDR_W];
        wr_sel_s.data = wr_req_data[int'(wr_idx_s)*DATA_W +: DATA_W];
        wr_sel_s.mask = wr_req_mask[int'(wr_idx_s)*DATA_W +: DATA_W];
    end

    // Reset is folded into the fill enable so the macro sees an idle write port while reset is held.
    assign run_s     = (state_q == ST_RUN);
    assign fill_s    = (state_q == ST_INIT) && !reset;
    assign rd_any_s  = |rd_req_valid;
    assign wr_any_s  = |wr_req_valid;
    assign addr_eq_s = (rd_sel_s.addr == wr_sel_s.addr);

`ifdef RF_BYPASS_EN
    logic                byp_pend_q;
    logic                p1_merge_q;
    logic [ADDR_W-1:0]   byp_addr_q;
    logic [RD_IDX_W-1:0] byp_idx_q;
    logic [DATA_W-1:0]   byp_data_q;
    logic [DATA_W-1:0]   byp_mask_q;

    // Both ports pause for the re-read cycle so response order is kept and the re-read cannot collide.
    assign rd_allow_s = run_s && !byp_pend_q;
    assign wr_allow_s = run_s && !byp_pend_q;
    assign collide_s  = rd_allow_s && rd_any_s && wr_allow_s && wr_any_s && addr_eq_s;
    assign rd_fire_s  = rd_allow_s && rd_any_s;
    assign rd_issue_s = (rd_fire_s && !collide_s) || byp_pend_q;

    // Capture the colliding write so the delayed read can be merged with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_pend_q <= 1'b0;
            p1_merge_q <= 1'b0;
            byp_addr_q <= {ADDR_W{1'b0}};
            byp_idx_q  <= {RD_IDX_W{1'b0}};
            byp_data_q <= {DATA_W{1'b0}};
            byp_mask_q <= {DATA_W{1'b0}};
        end else begin
            byp_pend_q <= collide_s;
            p1_merge_q <= byp_pend_q;
            if (collide_s) begin
                byp_addr_q <= rd_sel_s.addr;
                byp_idx_q  <= rd_idx_s;
                byp_data_q <= wr_sel_s.data;
                byp_mask_q <= wr_sel_s.mask;
            end
        end
    end

    // Read port drive: the pending re-read has priority over new grants.
    always_comb begin
        ram_cena   = 1'b1;
        ram_aa     = {ADDR_W{1'b0}};
        p1_idx_d   = rd_idx_s;
        rsp_data_d = ram_qa;
        if (byp_pend_q) begin
            ram_cena = 1'b0;
            ram_aa   = byp_addr_q;
            p1_idx_d = byp_idx_q;
        end else if (rd_issue_s) begin
            ram_cena = 1'b0;
            ram_aa   = rd_sel_s.addr;
        end else begin
            ram_cena = 1'b1;
        end
        if (p1_merge_q) begin
            rsp_data_d = merge_masked(ram_qa, byp_data_q, byp_mask_q);
        end else begin
            rsp_data_d = ram_qa;
        end
    end
`else
    // A read that would hit the address being written this cycle is held off one cycle.
    assign wr_allow_s = run_s;
    assign collide_s  = run_s && rd_any_s && wr_any_s && addr_eq_s;
    assign rd_allow_s = run_s && !collide_s;
    assign rd_fire_s  = rd_allow_s && rd_any_s;
    assign rd_issue_s = rd_fire_s;

    // Read port drive for the granted read.
    always_comb begin
        ram_cena   = 1'b1;
        ram_aa     = {ADDR_W{1'b0}};
        p1_idx_d   = rd_idx_s;
        rsp_data_d = ram_qa;
        if (rd_issue_s) begin
            ram_cena = 1'b0;
            ram_aa   = rd_sel_s.addr;
        end else begin
            ram_cena = 1'b1;
        end
    end
`endif

    assign wr_fire_s    = wr_allow_s && wr_any_s;
    assign rd_req_ready = rd_allow_s ? rd_gnt_s : {NUM_RD{1'b0}};
    assign wr_req_ready = wr_allow_s ? wr_gnt_s : {NUM_WR{1'b0}};

    // Write port drive: zero-fill during init, otherwise the granted masked write.
    always_comb begin
        ram_cenb = 1'b1;
        ram_wenb = {DATA_W{1'b1}};
        ram_ab   = {ADDR_W{1'b0}};
        ram_db   = {DATA_W{1'b0}};
        if (fill_s) begin
            ram_cenb = 1'b0;
            ram_ab   = init_addr_q;
            ram_wenb = {DATA_W{1'b0}};
        end else if (wr_fire_s) begin
            ram_cenb = 1'b0;
            ram_ab   = wr_sel_s.addr;
            ram_db   = wr_sel_s.data;
            ram_wenb = ~wr_sel_s.mask;
        end else begin
            ram_cenb = 1'b1;
        end
    end

    // Init/run sequencer: 32 zero-fill cycles, then run until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= {ADDR_W{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_addr_q == ADDR_W'(RF_DEPTH-1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                        init_addr_q <= {ADDR_W{1'b0}};
                    end else begin
                        init_addr_q <= init_addr_q + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_INIT;
                    init_addr_q <= {ADDR_W{1'b0}};
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Read response pipeline: issue -> macro output cycle -> registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid_q  <= 1'b0;
            p1_idx_q    <= {RD_IDX_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= {RD_IDX_W{1'b0}};
            rsp_data_q  <= {DATA_W{1'b0}};
        end else begin
            p1_valid_q  <= rd_issue_s;
            p1_idx_q    <= p1_idx_d;
            rsp_valid_q <= p1_valid_q;
            if (p1_valid_q) begin
                rsp_idx_q  <= p1_idx_q;
                rsp_data_q <= rsp_data_d;
            end
        end
    end

    assign init_done    = init_done_q;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_idx   = rsp_idx_q;
    assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf2_32x128_ctrl.sv
// Directed bench for rf2_32x128_ctrl in its default build (RF_BYPASS_EN undefined),
// with a behavioural two-port macro model holding garbage until the controller fills it.
module tb_rf2_32x128_ctrl;

    localparam logic [127:0] Z     = 128'h0;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] D2    = {4{32'h0000_0002}};
    localparam logic [127:0] M96   = {{96{1'b1}}, {32{1'b0}}};
    localparam logic [127:0] WM96  = {{96{1'b0}}, {32{1'b1}}};
    localparam logic [127:0] MRG   = 128'h0000_0002_0000_0002_0000_0002_0000_0000;
    localparam logic [127:0] D7    = {16{8'h77}};

    logic         clk = 1'b0;
    logic         reset;
    logic         init_done;
    logic [1:0]   rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
    logic [9:0]   rd_req_addr, wr_req_addr;
    logic         rd_rsp_valid;
    logic [0:0]   rd_rsp_idx;
    logic [127:0] rd_rsp_data;
    logic [255:0] wr_req_data, wr_req_mask;
    logic         ram_cena, ram_cenb;
    logic [4:0]   ram_aa, ram_ab;
    logic [127:0] ram_qa, ram_wenb, ram_db;

    int n_checks = 0;
    int n_fail   = 0;

    rf2_32x128_ctrl #(.NUM_RD(2), .NUM_WR(2)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_idx(rd_rsp_idx), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_mask(wr_req_mask), .wr_req_ready(wr_req_ready),
        .ram_cena(ram_cena), .ram_aa(ram_aa), .ram_qa(ram_qa),
        .ram_cenb(ram_cenb), .ram_wenb(ram_wenb), .ram_ab(ram_ab), .ram_db(ram_db)
    );

    always #5 clk = ~clk;

    // Macro model: read-before-write, active-low per-bit write enables, random power-up contents.
    logic [127:0] mem [32];
    bit           seeded_q;
    always @(posedge clk) begin
        if (!seeded_q) begin
            for (int i = 0; i < 32; i++) mem[i] <= {$urandom, $urandom, $urandom, $urandom};
            seeded_q <= 1'b1;
        end else begin
            if (!ram_cena) ram_qa <= mem[ram_aa];
            if (!ram_cenb) mem[ram_ab] <= (mem[ram_ab] & ram_wenb) | (ram_db & ~ram_wenb);
        end
    end

    // The macro must never be read and written at the same address in one cycle.
    always @(negedge clk) begin
        if (init_done && !ram_cena && !ram_cenb) begin
            n_checks++;
            if (ram_aa == ram_ab) begin
                n_fail++;
                $display("FAIL collision: aa=%h ab=%h", ram_aa, ram_ab);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] rd_v; logic [4:0] rd_a0, rd_a1;
        logic [1:0] wr_v; logic [4:0] wr_a; logic [127:0] wr_d, wr_m;
        logic [1:0] e_rrdy, e_wrdy;
        logic e_cena; logic [4:0] e_aa;
        logic e_cenb; logic [4:0] e_ab; logic [127:0] e_wenb, e_db;
        logic e_rv; logic e_ridx; logic [127:0] e_rd;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [1:0] rv_in, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [1:0] wv_in, input logic [4:0] wa, input logic [127:0] wd,
                           input logic [127:0] wm, input logic [1:0] rrdy, input logic [1:0] wrdy,
                           input logic cena, input logic [4:0] aa, input logic cenb,
                           input logic [4:0] ab, input logic [127:0] wenb, input logic [127:0] db,
                           input logic rv, input logic ridx, input logic [127:0] rd);
        vec_t v;
        v.rd_v = rv_in; v.rd_a0 = a0; v.rd_a1 = a1; v.wr_v = wv_in; v.wr_a = wa; v.wr_d = wd; v.wr_m = wm;
        v.e_rrdy = rrdy; v.e_wrdy = wrdy; v.e_cena = cena; v.e_aa = aa; v.e_cenb = cenb; v.e_ab = ab;
        v.e_wenb = wenb; v.e_db = db; v.e_rv = rv; v.e_ridx = ridx; v.e_rd = rd;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input logic rv, input logic ridx, input logic [127:0] rd);
        add_vec(2'b00, 5'h0, 5'h0, 2'b00, 5'h0, Z, Z, 2'b00, 2'b00, 1'b1, 5'h0, 1'b1, 5'h0, ONES, Z, rv, ridx, rd);
    endtask

    task automatic idle_inputs();
        rd_req_valid = 2'b00; rd_req_addr = 10'h0;
        wr_req_valid = 2'b00; wr_req_addr = 10'h0; wr_req_data = 256'h0; wr_req_mask = 256'h0;
    endtask

    // Expects reset just released before the coming negedge: 32 fill cycles, then init_done.
    task automatic check_init();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk($sformatf("init%0d cenb", k), ram_cenb, 1'b0);
            chk($sformatf("init%0d ab", k), ram_ab, k[4:0]);
            chk($sformatf("init%0d wenb", k), ram_wenb, Z);
            chk($sformatf("init%0d db", k), ram_db, Z);
            chk($sformatf("init%0d done", k), init_done, 1'b0);
        end
        @(negedge clk);
        chk("init_done rise", init_done, 1'b1);
        chk("post-init cenb", ram_cenb, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " init_done"}, init_done, 1'b0);
        chk({tag, " rd_ready"}, rd_req_ready, 2'b00);
        chk({tag, " wr_ready"}, wr_req_ready, 2'b00);
        chk({tag, " rsp_valid"}, rd_rsp_valid, 1'b0);
        chk({tag, " cena"}, ram_cena, 1'b1);
        chk({tag, " cenb"}, ram_cenb, 1'b1);
        chk({tag, " wenb"}, ram_wenb, ONES);
        chk({tag, " aa"}, ram_aa, 5'h0);
        chk({tag, " ab"}, ram_ab, 5'h0);
        chk({tag, " db"}, ram_db, Z);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        idle_inputs();
        rd_req_valid = 2'b11;
        wr_req_valid = 2'b11;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        chk("reset rsp_idx", rd_rsp_idx, 1'b0);
        chk("reset rsp_data", rd_rsp_data, Z);
        idle_inputs();
        @(posedge clk); #1 reset = 1'b0;
        check_init();

        //       rd_v   a0     a1     wr_v   wa     wd    wm    rrdy   wrdy   cena  aa     cenb  ab     wenb  db    rv    ridx  rd
        add_vec(2'b01, 5'h03, 5'h00, 2'b00, 5'h00, Z,    Z,    2'b01, 2'b00, 1'b0, 5'h03, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c0 read 03
        add_vec(2'b00, 5'h00, 5'h00, 2'b01, 5'h0A, D2,   M96,  2'b00, 2'b01, 1'b1, 5'h00, 1'b0, 5'h0A, WM96, D2,   1'b0, 1'b0, Z);    // c1 masked write 0A
        add_idle(1'b1, 1'b0, Z);                                                                                                        // c2 rsp of c0
        add_idle(1'b0, 1'b0, Z);
        add_idle(1'b0, 1'b0, Z);
        add_idle(1'b0, 1'b0, Z);
        add_vec(2'b10, 5'h00, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b10, 2'b00, 1'b0, 5'h0A, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c6 read 0A
        add_idle(1'b0, 1'b0, Z);
        add_idle(1'b1, 1'b1, MRG);                                                                                                      // c8
        add_vec(2'b11, 5'h01, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b01, 2'b00, 1'b0, 5'h01, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c9 alternate
        add_vec(2'b11, 5'h01, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b10, 2'b00, 1'b0, 5'h0A, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);
        add_vec(2'b11, 5'h01, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b01, 2'b00, 1'b0, 5'h01, 1'b1, 5'h00, ONES, Z,    1'b1, 1'b0, Z);
        add_vec(2'b11, 5'h01, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b10, 2'b00, 1'b0, 5'h0A, 1'b1, 5'h00, ONES, Z,    1'b1, 1'b1, MRG);
        add_idle(1'b1, 1'b0, Z);                                                                                                        // c13
        add_idle(1'b1, 1'b1, MRG);                                                                                                      // c14
        add_vec(2'b00, 5'h00, 5'h00, 2'b10, 5'h05, ONES, ONES, 2'b00, 2'b10, 1'b1, 5'h00, 1'b0, 5'h05, Z,    ONES, 1'b0, 1'b0, Z);    // c15 write 05
        add_vec(2'b01, 5'h05, 5'h00, 2'b00, 5'h00, Z,    Z,    2'b01, 2'b00, 1'b0, 5'h05, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c16 RAW read
        add_idle(1'b0, 1'b0, Z);
        add_idle(1'b1, 1'b0, ONES);                                                                                                     // c18
        add_vec(2'b00, 5'h00, 5'h00, 2'b01, 5'h0A, ONES, Z,    2'b00, 2'b01, 1'b1, 5'h00, 1'b0, 5'h0A, ONES, ONES, 1'b0, 1'b0, Z);    // c19 zero mask
        add_vec(2'b01, 5'h07, 5'h00, 2'b01, 5'h07, D7,   ONES, 2'b00, 2'b01, 1'b1, 5'h00, 1'b0, 5'h07, Z,    D7,   1'b0, 1'b0, Z);    // c20 collision
        add_vec(2'b01, 5'h07, 5'h00, 2'b00, 5'h00, Z,    Z,    2'b01, 2'b00, 1'b0, 5'h07, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c21 retry
        add_vec(2'b10, 5'h00, 5'h0A, 2'b00, 5'h00, Z,    Z,    2'b10, 2'b00, 1'b0, 5'h0A, 1'b1, 5'h00, ONES, Z,    1'b0, 1'b0, Z);    // c22
        add_idle(1'b1, 1'b0, D7);                                                                                                       // c23
        add_idle(1'b1, 1'b1, MRG);                                                                                                      // c24
        add_idle(1'b0, 1'b0, Z);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            rd_req_valid = vecs[k].rd_v;
            rd_req_addr  = {vecs[k].rd_a1, vecs[k].rd_a0};
            wr_req_valid = vecs[k].wr_v;
            wr_req_addr  = {vecs[k].wr_a, vecs[k].wr_a};
            wr_req_data  = {vecs[k].wr_d, vecs[k].wr_d};
            wr_req_mask  = {vecs[k].wr_m, vecs[k].wr_m};
            @(negedge clk);
            chk($sformatf("c%0d rd_ready", k), rd_req_ready, vecs[k].e_rrdy);
            chk($sformatf("c%0d wr_ready", k), wr_req_ready, vecs[k].e_wrdy);
            chk($sformatf("c%0d cena", k), ram_cena, vecs[k].e_cena);
            if (!vecs[k].e_cena) chk($sformatf("c%0d aa", k), ram_aa, vecs[k].e_aa);
            chk($sformatf("c%0d cenb", k), ram_cenb, vecs[k].e_cenb);
            if (!vecs[k].e_cenb) begin
                chk($sformatf("c%0d ab", k), ram_ab, vecs[k].e_ab);
                chk($sformatf("c%0d db", k), ram_db, vecs[k].e_db);
            end
            chk($sformatf("c%0d wenb", k), ram_wenb, vecs[k].e_wenb);
            chk($sformatf("c%0d rsp_valid", k), rd_rsp_valid, vecs[k].e_rv);
            if (vecs[k].e_rv) begin
                chk($sformatf("c%0d rsp_idx", k), rd_rsp_idx, vecs[k].e_ridx);
                chk($sformatf("c%0d rsp_data", k), rd_rsp_data, vecs[k].e_rd);
            end
        end

        // Reset while reads and writes stream: outputs drop at once, pending response is lost.
        @(posedge clk); #1;
        rd_req_valid = 2'b01; rd_req_addr = {5'h00, 5'h0A};
        wr_req_valid = 2'b10; wr_req_addr = {5'h0B, 5'h0B};
        wr_req_data = {ONES, ONES}; wr_req_mask = {ONES, ONES};
        @(negedge clk);
        chk("stream rd_ready", rd_req_ready, 2'b01);
        chk("stream wr_ready", wr_req_ready, 2'b10);
        @(posedge clk); #1 reset = 1'b1;
        #1 check_reset_values("midrun");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("midrun hold%0d rsp_valid", k), rd_rsp_valid, 1'b0);
        end
        idle_inputs();
        @(posedge clk); #1 reset = 1'b0;
        check_init();

        // Entry 0B was written just before reset; the refill must have cleared it.
        @(posedge clk); #1 rd_req_valid = 2'b10; rd_req_addr = {5'h0B, 5'h00};
        @(negedge clk);
        chk("refill rd_ready", rd_req_ready, 2'b10);
        chk("refill aa", ram_aa, 5'h0B);
        @(posedge clk); #1 idle_inputs();
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (rd_rsp_valid) break;
        end
        chk("refill latency", lat, 2);
        chk("refill rsp_idx", rd_rsp_idx, 1'b1);
        chk("refill rsp_data", rd_rsp_data, Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
